// File: rtl/bp_pht_ctrl_if.sv
// Fetch/execute side of the gshare PHT controller:
// lookup request, prediction return and resolve queue.
interface bp_pht_ctrl_if #(
  parameter int IDX_W = 10
) ();
  logic             lookup_valid_i;
  logic [IDX_W-1:0] lookup_pc_i;
  logic             lookup_ready_o;
  logic             predict_valid_o;
  logic             predict_taken_o;
  logic             resolve_valid_i;
  logic [IDX_W-1:0] resolve_pc_i;
  logic             resolve_taken_i;
  logic             resolve_ready_o;

  modport master (
    output lookup_valid_i,
    output lookup_pc_i,
    input  lookup_ready_o,
    input  predict_valid_o,
    input  predict_taken_o,
    output resolve_valid_i,
    output resolve_pc_i,
    output resolve_taken_i,
    input  resolve_ready_o
  );

  modport slave (
    input  lookup_valid_i,
    input  lookup_pc_i,
    output lookup_ready_o,
    output predict_valid_o,
    output predict_taken_o,
    input  resolve_valid_i,
    input  resolve_pc_i,
    input  resolve_taken_i,
    output resolve_ready_o
  );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Single-port PHT sequencer: table clear, GHR,
// resolve queue and lookup/update port arbitration.
module bp_pht_ctrl #(
  parameter int IDX_W  = 10,
  parameter int QDEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  bp_pht_ctrl_if.slave     bus,
  output logic [IDX_W-1:0] ghr_o,
  output logic             init_done_o,
  output logic             pht_en_o,
  output logic             pht_we_o,
  output logic [IDX_W-1:0] pht_addr_o,
  output logic [1:0]       pht_wdata_o,
  input  logic [1:0]       pht_rdata_i
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_WR
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_q;
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic [QDEPTH-1:0] q_tk;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             done_q, pv_q;

  logic             full, push, pop;
  logic             lk_rdy, lk_acc;
  logic             en_c, we_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;
  logic [IDX_W-1:0] head_idx;
  logic             head_tk;
  logic [1:0]       cur;

  assign full     = (cnt_q == FULL);
  assign head_idx = q_idx[rptr_q];
  assign head_tk  = q_tk[rptr_q];
  assign cur      = pht_rdata_i;

  assign bus.resolve_ready_o = !full;
  assign push   = bus.resolve_valid_i && !full;
  assign lk_acc = bus.lookup_valid_i && lk_rdy;

  always_comb begin
    state_d = state_q;
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = init_q;
    wdata_c = 2'b00;
    pop     = 1'b0;
    lk_rdy  = 1'b0;
    unique case (state_q)
      INIT: begin
        en_c = 1'b1;
        we_c = 1'b1;
        if (&init_q) state_d = IDLE;
      end
      IDLE: begin
        if (full) begin
          en_c    = 1'b1;
          addr_c  = head_idx;
          state_d = UPD_WR;
        end else begin
          lk_rdy = 1'b1;
          if (bus.lookup_valid_i) begin
            en_c   = 1'b1;
            addr_c = bus.lookup_pc_i ^ ghr_q;
          end else if (cnt_q != '0) begin
            en_c    = 1'b1;
            addr_c  = head_idx;
            state_d = UPD_WR;
          end
        end
      end
      UPD_WR: begin
        en_c   = 1'b1;
        we_c   = 1'b1;
        addr_c = head_idx;
        pop    = 1'b1;
        // 2-bit saturating counter step
        if (head_tk)
          wdata_c = (cur == 2'b11) ? cur : cur + 2'b01;
        else
          wdata_c = (cur == 2'b00) ? cur : cur - 2'b01;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Port is held off while reset is asserted.
  assign pht_en_o    = en_c & rst_ni;
  assign pht_we_o    = we_c & rst_ni;
  assign pht_addr_o  = addr_c;
  assign pht_wdata_o = wdata_c;

  assign bus.lookup_ready_o  = lk_rdy;
  assign bus.predict_valid_o = pv_q;
  assign bus.predict_taken_o = pv_q & pht_rdata_i[1];
  assign ghr_o       = ghr_q;
  assign init_done_o = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      init_q  <= '0;
      ghr_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= lk_acc;
      if (state_q == INIT) begin
        init_q <= init_q + 1'b1;
        if (&init_q) done_q <= 1'b1;
      end
      if (push) begin
        ghr_q  <= {ghr_q[IDX_W-2:0], bus.resolve_taken_i};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_idx[wptr_q] <= bus.resolve_pc_i ^ ghr_q;
      q_tk[wptr_q]  <= bus.resolve_taken_i;
    end
  end
endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Directed + random bench for bp_pht_ctrl with an
// SRAM model and an in-order update reference model.
module tb_bp_pht_ctrl;
  localparam int IDX_W  = 10;
  localparam int QDEPTH = 4;
  localparam int DEPTH  = 1 << IDX_W;

  typedef struct {
    int idx;
    int tk;
  } ent_t;

  logic             clk;
  logic             rst_ni;
  logic [IDX_W-1:0] ghr_o;
  logic             init_done_o;
  logic             pht_en_o;
  logic             pht_we_o;
  logic [IDX_W-1:0] pht_addr_o;
  logic [1:0]       pht_wdata_o;
  logic [1:0]       pht_rdata_i;
  logic [1:0]       mem [DEPTH];

  bp_pht_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bp_pht_ctrl #(
    .IDX_W (IDX_W),
    .QDEPTH(QDEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (bus.slave),
    .ghr_o      (ghr_o),
    .init_done_o(init_done_o),
    .pht_en_o   (pht_en_o),
    .pht_we_o   (pht_we_o),
    .pht_addr_o (pht_addr_o),
    .pht_wdata_o(pht_wdata_o),
    .pht_rdata_i(pht_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pht_en_o) begin
      if (pht_we_o) mem[pht_addr_o] <= pht_wdata_o;
      else          pht_rdata_i <= mem[pht_addr_o];
    end
  end

  int   n_cmp;
  int   n_err;
  int   ref_pht [DEPTH];
  ent_t mq [$];
  int   m_ghr;
  bit   m_init;
  int   init_addr;
  bit   exp_pv;
  int   exp_pt;
  bit   last_drain;
  int   stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input int t);
    int v;
    v = t ? c + 1 : c - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ghr = 0;
    foreach (ref_pht[i]) ref_pht[i] = 0;
    m_init    = 1'b1;
    init_addr = 0;
    exp_pv    = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst_en", pht_en_o, 0);
    chk("rst_we", pht_we_o, 0);
    chk("rst_addr", pht_addr_o, 0);
    chk("rst_wdata", pht_wdata_o, 0);
    chk("rst_ghr", ghr_o, 0);
    chk("rst_done", init_done_o, 0);
    chk("rst_lk_rdy", bus.lookup_ready_o, 0);
    chk("rst_pv", bus.predict_valid_o, 0);
    chk("rst_pt", bus.predict_taken_o, 0);
    chk("rst_res_rdy", bus.resolve_ready_o, 1);
  endtask

  // One clock: check outputs at negedge, advance the model.
  task automatic step();
    int   li;
    int   nw;
    bit   acc;
    ent_t e;
    @(negedge clk);
    chk("pred_valid", bus.predict_valid_o, exp_pv);
    chk("pred_taken", bus.predict_taken_o, exp_pv ? exp_pt : 0);
    chk("ghr", ghr_o, m_ghr);
    chk("res_ready", bus.resolve_ready_o, mq.size() < QDEPTH);
    if (mq.size() == QDEPTH)
      chk("lk_ready_full", bus.lookup_ready_o, 0);
    acc = bus.lookup_valid_i && bus.lookup_ready_o;
    li  = int'(bus.lookup_pc_i) ^ m_ghr;
    last_drain = 1'b0;
    if (m_init) begin
      chk("init_done_lo", init_done_o, 0);
      chk("init_lk_rdy", bus.lookup_ready_o, 0);
      chk("init_port", {pht_en_o, pht_we_o}, 2'b11);
      chk("init_addr", pht_addr_o, init_addr);
      chk("init_wdata", pht_wdata_o, 0);
      init_addr++;
      if (init_addr == DEPTH) m_init = 1'b0;
    end else begin
      chk("init_done_hi", init_done_o, 1);
      if (bus.lookup_valid_i && !bus.lookup_ready_o) stall_cnt++;
      if (acc) begin
        chk("lk_port", {pht_en_o, pht_we_o}, 2'b10);
        chk("lk_addr", pht_addr_o, li);
      end else if (pht_en_o && pht_we_o) begin
        chk("wr_has_entry", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          e  = mq.pop_front();
          nw = sat(ref_pht[e.idx], e.tk);
          chk("upd_addr", pht_addr_o, e.idx);
          chk("upd_wdata", pht_wdata_o, nw);
          ref_pht[e.idx] = nw;
        end
      end else if (pht_en_o) begin
        last_drain = 1'b1;
        if (mq.size() != 0) chk("drain_addr", pht_addr_o, mq[0].idx);
      end
    end
    if (acc) exp_pt = ref_pht[li] >> 1;
    exp_pv = acc;
    if (bus.resolve_valid_i && bus.resolve_ready_o) begin
      e.idx = int'(bus.resolve_pc_i) ^ m_ghr;
      e.tk  = int'(bus.resolve_taken_i);
      mq.push_back(e);
      m_ghr = (m_ghr * 2 + e.tk) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input bit v, input int pc, input bit tk);
    bus.resolve_valid_i = v;
    bus.resolve_pc_i    = IDX_W'(pc);
    bus.resolve_taken_i = tk;
  endtask

  task automatic set_lk(input bit v, input int pc);
    bus.lookup_valid_i = v;
    bus.lookup_pc_i    = IDX_W'(pc);
  endtask

  initial begin
    int hidx;
    int hv;
    bit found;
    n_cmp     = 0;
    n_err     = 0;
    stall_cnt = 0;
    exp_pt    = 0;
    rst_ni    = 1'b0;
    set_lk(0, 0);
    set_res(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    model_reset();
    rst_ni = 1'b1;
    repeat (DEPTH) step();
    step();

    // GHR-driven indices 5, 4, 6 from three taken resolves
    for (int i = 0; i < 3; i++) begin
      set_res(1, 5, 1);
      step();
    end
    set_res(0, 0, 0);
    repeat (8) step();
    chk("ghr_after_3", ghr_o, 7);
    chk("ctr_5", mem[5], 1);
    chk("ctr_4", mem[4], 1);
    chk("ctr_6", mem[6], 1);
    set_lk(1, 5);
    step();
    set_lk(0, 0);
    step();

    // Lookups every cycle while the queue fills
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      set_lk(1, $urandom_range(0, 31));
      set_res(1, $urandom_range(0, 31), 1'($urandom));
      step();
    end
    set_res(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      set_lk(1, $urandom_range(0, 31));
      step();
    end
    chk("full_stall_cycles", stall_cnt, 2);
    set_lk(0, 0);
    repeat (10) step();

    // Random traffic with colliding indices
    for (int i = 0; i < 800; i++) begin
      set_lk($urandom_range(0, 99) < 55, $urandom_range(0, 15));
      set_res($urandom_range(0, 99) < 50, $urandom_range(0, 15),
              $urandom_range(0, 99) < 70);
      step();
    end
    set_lk(0, 0);
    set_res(0, 0, 0);
    repeat (12) step();

    // Three queued, push+pop at count 3, then reset in UPD_WR
    set_lk(1, 3);
    for (int i = 0; i < 3; i++) begin
      set_res(1, $urandom_range(0, 63), 1);
      step();
    end
    set_lk(0, 0);
    set_res(0, 0, 0);
    step();
    set_res(1, 9, 0);
    step();
    set_res(0, 0, 0);
    chk("q3_after_pushpop", mq.size(), 3);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      found = last_drain;
    end
    chk("drain_seen", found, 1);
    hidx   = (mq.size() != 0) ? mq[0].idx : 0;
    hv     = ref_pht[hidx];
    rst_ni = 1'b0;
    #1;
    chk("rst_upd_we", pht_we_o, 0);
    chk("rst_upd_en", pht_en_o, 0);
    @(posedge clk);
    #1;
    chk("rst_no_write", mem[hidx], hv);
    reset_checks();
    model_reset();
    rst_ni = 1'b1;
    repeat (DEPTH) step();
    for (int i = 0; i < 5; i++) begin
      chk("idle_port", pht_en_o, 0);
      step();
    end
    set_lk(1, 2);
    step();
    set_lk(0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
